expr_sched: RTL and testbench

- Scheduler that shares one expr checker between two character-stream requesters.
- The checker is the ASCII recogniser for strings of the form digit((+|*)digit)*. It has clock-enable and clear inputs, and its out is a Moore output.
- The block arbitrates whole strings, clears the checker before each string, and forwards accepted characters one per handshake. It samples the verdict after the last character and returns it to the granted requester.

---
 rtl/expr_sched_if.sv | 28 ++
 rtl/expr_sched.sv | 101 ++++++++++
 tb/tb_expr_sched.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/expr_sched_if.sv
// Handshake bundle between expr_sched, its two requesters, the shared
// expr checker and the result consumer.
interface expr_sched_if #(
  parameter int LEN_W = 8
);
  logic             req0_valid, req0_last, req0_ready;
  logic [7:0]       req0_data;
  logic             req1_valid, req1_last, req1_ready;
  logic [7:0]       req1_data;
  logic             chk_clr, chk_en, chk_out;
  logic [7:0]       chk_in;
  logic             res_valid, res_id, res_ok, res_err, res_ready;
  logic [LEN_W-1:0] res_len;

  modport master (
    output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last,
           chk_out, res_ready,
    input  req0_ready, req1_ready, chk_clr, chk_en, chk_in,
           res_valid, res_id, res_ok, res_err, res_len
  );

  modport slave (
    input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last,
           chk_out, res_ready,
    output req0_ready, req1_ready, chk_clr, chk_en, chk_in,
           res_valid, res_id, res_ok, res_err, res_len
  );
endinterface

// File: rtl/expr_sched.sv
// Shares one expr checker between two requesters, one whole string at a time.
// Optional stall abort: define EXPR_SCHED_TIMEOUT_EN.
module expr_sched #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 8
) (
  input logic         clk,
  input logic         clr,
  expr_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLR, STREAM, EVAL, RESP} state_t;

  state_t           st, nx;
  logic             grant, last_grant, err;
  logic [LEN_W-1:0] len;
  logic             gvalid, glast, hs, fwd, to_hit;
  logic [7:0]       gdata;

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT < 1 || (1 << LEN_W) <= MAX_LEN) begin : g_bad_param
    $error("expr_sched: parameter out of range");
  end

  assign gvalid = grant ? bus.req1_valid : bus.req0_valid;
  assign glast  = grant ? bus.req1_last  : bus.req0_last;
  assign gdata  = grant ? bus.req1_data  : bus.req0_data;
  assign hs     = (st == STREAM) && gvalid;
  // characters beyond MAX_LEN are swallowed so the requester never stalls
  assign fwd    = hs && (len < LEN_W'(MAX_LEN));

`ifdef EXPR_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  assign to_hit = (st == STREAM) && !gvalid && (tcnt == TW'(TIMEOUT - 1));
  always_ff @(posedge clk) begin
    if (!clr || st != STREAM || gvalid) tcnt <= '0;
    else                                tcnt <= tcnt + TW'(1);
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    nx = st;
    case (st)
      IDLE:    if (bus.req0_valid || bus.req1_valid) nx = CLR;
      CLR:     nx = STREAM;
      STREAM:  if ((hs && glast) || to_hit) nx = EVAL;
      EVAL:    nx = RESP;
      RESP:    if (bus.res_ready) nx = IDLE;
      default: nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) st <= IDLE;
    else      st <= nx;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      len         <= '0;
      err         <= 1'b0;
      bus.res_id  <= 1'b0;
      bus.res_ok  <= 1'b0;
      bus.res_err <= 1'b0;
      bus.res_len <= '0;
    end else begin
      case (st)
        IDLE: if (bus.req0_valid || bus.req1_valid)
                grant <= (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
        CLR: begin
          len <= '0;
          err <= 1'b0;
        end
        STREAM: begin
          if (fwd)     len <= len + LEN_W'(1);
          else if (hs) err <= 1'b1;
          if (to_hit)  err <= 1'b1;
        end
        EVAL: begin
          bus.res_ok  <= bus.chk_out & ~err;
          bus.res_err <= err;
          bus.res_len <= len;
          bus.res_id  <= grant;
        end
        RESP: if (bus.res_ready) last_grant <= grant;
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = clr && (st == STREAM) && !grant;
  assign bus.req1_ready = clr && (st == STREAM) && grant;
  assign bus.chk_clr    = !clr || (st == CLR);
  assign bus.chk_en     = clr && fwd;
  assign bus.chk_in     = gdata;
  assign bus.res_valid  = (st == RESP);
endmodule

// File: tb/tb_expr_sched.sv
// Randomized bench for expr_sched with a behavioural expr checker and result model.
module tb_expr_sched;
  localparam int MAX_LEN = 16, LEN_W = 8, TIMEOUT = 8;

  logic clk = 1'b0, clr = 1'b0;
  always #5 clk = ~clk;

  expr_sched_if #(.LEN_W(LEN_W)) bus ();
  expr_sched #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clr(clr), .bus(bus)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // digit((+|*)digit)*
  function automatic bit is_expr(input byte s[$]);
    if (s.size() % 2 == 0) return 1'b0;
    foreach (s[i]) begin
      if (i % 2 == 0) begin
        if (s[i] < "0" || s[i] > "9") return 1'b0;
      end else if (s[i] != "+" && s[i] != "*") return 1'b0;
    end
    return 1'b1;
  endfunction

  // checker model: remembers everything consumed since the last clear
  byte  cq[$];
  int   en_cnt = 0;
  logic chk_m  = 1'b0;
  always @(posedge clk) begin
    if (bus.chk_clr) begin
      cq.delete();
      en_cnt = 0;
    end else if (bus.chk_en) begin
      cq.push_back(bus.chk_in);
      en_cnt++;
    end
    chk_m <= is_expr(cq);
  end
  assign bus.chk_out = chk_m;

  always @(negedge clk) if (clr) begin
    chk("rdy_excl", bus.req0_ready & bus.req1_ready, 0);
    chk("en_no_hs", bus.chk_en & !((bus.req0_valid & bus.req0_ready) |
                                   (bus.req1_valid & bus.req1_ready)), 0);
  end

  typedef struct { bit id; bit ok; bit err; int len; } res_t;
  res_t exp_q[$];
  bit   last_grant_m;

  function automatic res_t model(input bit id, input string s);
    res_t r;
    byte  b[$];
    for (int i = 0; i < s.len(); i++) b.push_back(s[i]);
    r.id  = id;
    r.err = s.len() > MAX_LEN;
    r.len = r.err ? MAX_LEN : s.len();
    r.ok  = !r.err && is_expr(b);
    return r;
  endfunction

  task automatic set_req(input int id, input logic v, input logic [7:0] d, input logic l);
    if (id == 0) begin bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l; end
    else         begin bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l; end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  task automatic send_char(input int id, input byte c, input logic l, output bit ok);
    int cnt = 0;
    @(negedge clk);
    set_req(id, 1'b1, c, l);
    while (!rdy(id) && cnt < 1000) begin @(negedge clk); cnt++; end
    ok = (cnt < 1000);
    if (!ok) begin
      chk("hs_timeout", 0, 1);
      set_req(id, 1'b0, 8'h00, 1'b0);
    end else @(posedge clk);
  endtask

  task automatic drive(input int id, input string s);
    bit ok;
    for (int i = 0; i < s.len(); i++) begin
      if (i > 0) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin @(negedge clk); set_req(id, 1'b0, 8'h00, 1'b0); end
      end
      send_char(id, s[i], i == s.len() - 1, ok);
      if (!ok) return;
    end
    @(negedge clk);
    set_req(id, 1'b0, 8'h00, 1'b0);
    chk("lat_eval", bus.res_valid, 0);
    @(negedge clk);
    chk("lat_resp", bus.res_valid, 1);
  endtask

  task automatic collect(input int n);
    repeat (n) begin
      res_t e;
      int   cnt = 0, k;
      while (!bus.res_valid && cnt < 2000) begin @(negedge clk); cnt++; end
      if (cnt >= 2000) begin chk("res_timeout", 0, 1); return; end
      e = exp_q.pop_front();
      k = $urandom_range(0, 5);
      for (int j = 0; j <= k; j++) begin
        if (j > 0) @(negedge clk);
        chk("res_valid", bus.res_valid, 1);
        chk("res_id",    bus.res_id,    e.id);
        chk("res_ok",    bus.res_ok,    e.ok);
        chk("res_err",   bus.res_err,   e.err);
        chk("res_len",   bus.res_len,   e.len);
        chk("fwd_cnt",   en_cnt,        e.len);
        chk("resp_rdy",  bus.req0_ready | bus.req1_ready, 0);
        chk("resp_clr",  bus.chk_clr,   0);
        if (j == k) bus.res_ready = 1'b1;
      end
      @(posedge clk);
      #1 bus.res_ready = 1'b0;
      @(negedge clk);
      chk("res_drop", bus.res_valid, 0);
    end
  endtask

  task automatic round(input string s0, input bit v0, input string s1, input bit v1);
    bit first;
    first = (v0 && v1) ? ~last_grant_m : v1;
    exp_q.push_back(model(first, first ? s1 : s0));
    if (v0 && v1) exp_q.push_back(model(~first, first ? s0 : s1));
    last_grant_m = (v0 && v1) ? ~first : first;
    fork
      begin if (v0) drive(0, s0); end
      begin if (v1) drive(1, s1); end
      collect((v0 && v1) ? 2 : 1);
    join
  endtask

  function automatic string rand_str();
    int    n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : $urandom_range(1, 16);
    string s = "";
    for (int i = 0; i < n; i++) begin
      byte c;
      if (i % 2 == 0) c = 8'("0" + $urandom_range(0, 9));
      else            c = $urandom_range(0, 1) ? "+" : "*";
      if ($urandom_range(0, 11) == 0) c = $urandom_range(0, 1) ? "x" : "+";
      s = $sformatf("%s%c", s, c);
    end
    return s;
  endfunction

  initial begin
    string long_s = "";
    bit    ok;
    bus.res_ready = 1'b0;
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_clr",   bus.chk_clr, 1);
    chk("rst_en",    bus.chk_en, 0);
    chk("rst_rdy",   {bus.req0_ready, bus.req1_ready}, 0);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_res",   {bus.res_id, bus.res_ok, bus.res_err, bus.res_len}, 0);
    clr = 1'b1;
    last_grant_m = 1'b1;
    @(negedge clk);
    chk("idle_rdy",  {bus.req0_ready, bus.req1_ready}, 0);

    round("1+2*3", 1, "", 0);
    round("", 0, "1+", 1);
    round("3*4", 1, "5+6", 1);
    round("1", 1, "2*2", 1);
    for (int i = 0; i < 17; i++) long_s = {long_s, (i % 2 == 0) ? "1" : "+"};
    round(long_s, 1, "", 0);
    repeat (30) begin
      bit a = 1'($urandom_range(0, 1));
      bit b = a ? 1'($urandom_range(0, 1)) : 1'b1;
      round(rand_str(), a, rand_str(), b);
    end

    // reset in the middle of a string discards it
    send_char(0, "1", 1'b0, ok);
    if (ok) send_char(0, "+", 1'b0, ok);
    @(negedge clk);
    set_req(0, 1'b0, 8'h00, 1'b0);
    clr = 1'b0;
    @(negedge clk);
    chk("mid_clr",   bus.chk_clr, 1);
    chk("mid_en",    bus.chk_en, 0);
    chk("mid_rdy",   {bus.req0_ready, bus.req1_ready}, 0);
    chk("mid_valid", bus.res_valid, 0);
    chk("mid_res",   {bus.res_id, bus.res_ok, bus.res_err, bus.res_len}, 0);
    clr = 1'b1;
    last_grant_m = 1'b1;
    @(negedge clk);
    chk("mid_none",  bus.res_valid, 0);
    round("7", 1, "", 0);

`ifdef EXPR_SCHED_TIMEOUT_EN
    begin
      res_t e;
      e.id = 1'b0; e.ok = 1'b0; e.err = 1'b1; e.len = 1;
      exp_q.push_back(e);
      last_grant_m = 1'b0;
      send_char(0, "1", 1'b0, ok);
      @(negedge clk);
      set_req(0, 1'b0, 8'h00, 1'b0);
      collect(1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
